// File: rtl/gpio_input_debouncer.sv
// -----------------------------------------------------------------------------
// gpio_input_debouncer
//
// Per-channel synchroniser and debouncer for raw board buttons and switches.
// Each raw pad input goes through a 2-flop synchroniser. A per-channel run
// counter then tracks how many consecutive cycles the synchronised level has
// disagreed with the accepted (debounced) level. A new level is accepted only
// after it has held for STABLE_CYCLES consecutive clocks. Any agreement in
// between (a glitch or bounce) clears the counter and leaves the output alone.
//
// Ports
//   clk         in   1        system clock
//   arst_n      in   1        asynchronous active-low reset
//   in_raw      in   NUM_CH   raw asynchronous pad inputs
//   db_out      out  NUM_CH   debounced levels
//   rise_pulse  out  NUM_CH   1-cycle pulse in the cycle db_out[i] first shows 1
//   fall_pulse  out  NUM_CH   1-cycle pulse in the cycle db_out[i] first shows 0
//   any_event   out  1        registered OR of all pulses, one cycle later
//
// Parameters
//   NUM_CH         number of channels
//   STABLE_CYCLES  consecutive mismatched cycles needed to accept a level (>= 1)
//   CNT_WIDTH      counter width, 2**CNT_WIDTH >= STABLE_CYCLES
// -----------------------------------------------------------------------------
module gpio_input_debouncer #(
    parameter int NUM_CH        = 9,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [NUM_CH-1:0] in_raw,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              any_event
);

    // Elaboration-time parameter sanity.
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("gpio_input_debouncer: STABLE_CYCLES must be >= 1");
    end
    if ((64'd1 << CNT_WIDTH) < 64'(STABLE_CYCLES)) begin : g_bad_width
        $error("gpio_input_debouncer: CNT_WIDTH too small for STABLE_CYCLES");
    end

    // Terminal count: the mismatch that arrives while the counter sits here
    // is the STABLE_CYCLES-th consecutive one, so it is accepted. With
    // STABLE_CYCLES == 1 this is zero and acceptance is immediate.
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [NUM_CH-1:0]    r_sync1;
    logic [NUM_CH-1:0]    r_sync2;
    logic [CNT_WIDTH-1:0] r_cnt [NUM_CH];
    logic [NUM_CH-1:0]    r_db;
    logic [NUM_CH-1:0]    r_rise;
    logic [NUM_CH-1:0]    r_fall;
    logic                 r_any;

    logic [CNT_WIDTH-1:0] w_cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0]    w_db_nxt;
    logic [NUM_CH-1:0]    w_rise_nxt;
    logic [NUM_CH-1:0]    w_fall_nxt;

    // Two-flop synchroniser; only r_sync2 feeds the debounce logic.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state logic for each channel's counter, level and edge pulses.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_db_nxt   = r_db;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_sync2[i] == r_db[i]) begin
                // Stable, or a glitch ended before acceptance: restart the run.
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] >= CNT_MAX) begin
                // Saturating compare: accept the new level and emit its edge.
                w_cnt_nxt[i]  = '0;
                w_db_nxt[i]   = r_sync2[i];
                w_rise_nxt[i] = r_sync2[i];
                w_fall_nxt[i] = ~r_sync2[i];
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    // Per-channel state and registered edge pulses.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_db   <= w_db_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    // Summary event flag, one stage behind the pulses.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |(r_rise | r_fall);
        end
    end

    assign db_out     = r_db;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign any_event  = r_any;

endmodule
